// File: rtl/seg7_probe_mux.sv
// seg7_probe_mux: debug probe viewer. Samples one of NUM_CH probe words,
// either periodically (every REFRESH_DIV clocks unless frozen) or when the
// debounced step button advances the channel, and drives it as hex digits
// on active-low seven-segment outputs.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   probe_data   NUM_CH*DATA_W, channel c at [c*DATA_W +: DATA_W]
//   btn_next     raw asynchronous step button, active-high
//   freeze       suppresses periodic sampling while high
//   ch_sel       displayed channel (registered)
//   sample_tick  one-cycle pulse on every capture (registered)
//   seg_out      NDIG*7, digit k at [k*7 +: 7], bit0=a..bit6=g, active-low
//
// Build option: define SEG7_LZ_BLANK_EN to blank leading-zero digits.
module seg7_probe_mux #(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned REFRESH_DIV  = 2500000,
  parameter int unsigned DEBOUNCE_CYC = 250000
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [NUM_CH*DATA_W-1:0]                      probe_data,
  input  logic                                          btn_next,
  input  logic                                          freeze,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] ch_sel,
  output logic                                          sample_tick,
  output logic [(DATA_W/4)*7-1:0]                       seg_out
);

  localparam int unsigned SEL_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned NDIG    = DATA_W / 4;
  localparam int unsigned SEG_W   = NDIG * 7;
  localparam int unsigned REF_W   = $clog2(REFRESH_DIV);
  localparam int unsigned DEB_TGT = (DEBOUNCE_CYC > 1) ? DEBOUNCE_CYC - 1 : 1;
  localparam int unsigned DEB_W   = $clog2(DEB_TGT + 1);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    ARM_PRESS   = 2'd1,
    HELD        = 2'd2,
    ARM_RELEASE = 2'd3
  } deb_state_t;

  // Standard hex glyphs, active-low, b and d lowercase
  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'h40;  4'h1: g = 7'h79;  4'h2: g = 7'h24;  4'h3: g = 7'h30;
      4'h4: g = 7'h19;  4'h5: g = 7'h12;  4'h6: g = 7'h02;  4'h7: g = 7'h78;
      4'h8: g = 7'h00;  4'h9: g = 7'h10;  4'hA: g = 7'h08;  4'hB: g = 7'h03;
      4'hC: g = 7'h46;  4'hD: g = 7'h21;  4'hE: g = 7'h06;  default: g = 7'h0E;
    endcase
    return g;
  endfunction

  // Whole-word encode; optional leading-zero blanking scans from the top digit
  function automatic logic [SEG_W-1:0] seg_encode(input logic [DATA_W-1:0] val);
    logic [SEG_W-1:0] seg;
`ifdef SEG7_LZ_BLANK_EN
    logic lead;
    lead = 1'b1;
`endif
    seg = '0;
    for (int k = int'(NDIG) - 1; k >= 0; k--) begin
      seg[k*7 +: 7] = hex_glyph(val[k*4 +: 4]);
`ifdef SEG7_LZ_BLANK_EN
      if (val[k*4 +: 4] != 4'h0) lead = 1'b0;
      if (lead && (k != 0)) seg[k*7 +: 7] = 7'h7F;
`endif
    end
    return seg;
  endfunction

  logic              btn_meta, btn_sync;
  deb_state_t        state_q, state_d;
  logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
  logic              step_c;
  logic              step_q;
  logic [REF_W-1:0]  ref_cnt_q;
  logic              ref_term_c;
  logic              cap_c;
  logic [DATA_W-1:0] slice_c;
  logic [DATA_W-1:0] cap_q;

  // Two-flop synchronizer for the raw button
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      btn_meta <= btn_next;
      btn_sync <= btn_meta;
    end
  end

  // Debounce state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      deb_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  // Debounce next-state: the sample that leaves IDLE/HELD counts as the first
  always_comb begin
    state_d   = state_q;
    deb_cnt_d = deb_cnt_q;
    step_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if (btn_sync) begin
          state_d   = ARM_PRESS;
          deb_cnt_d = DEB_W'(1);
        end
      end
      ARM_PRESS: begin
        if (!btn_sync) begin
          state_d = IDLE;
        end else if (deb_cnt_q >= DEB_W'(DEB_TGT)) begin
          state_d = HELD;
          step_c  = 1'b1;
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
      end
      HELD: begin
        if (!btn_sync) begin
          state_d   = ARM_RELEASE;
          deb_cnt_d = DEB_W'(1);
        end
      end
      default: begin
        if (btn_sync) begin
          state_d = HELD;
        end else if (deb_cnt_q >= DEB_W'(DEB_TGT)) begin
          state_d = IDLE;
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
      end
    endcase
  end

  // Channel slice for the current ch_sel
  always_comb begin
    slice_c = '0;
    for (int c = 0; c < int'(NUM_CH); c++) begin
      if (ch_sel == SEL_W'(c)) slice_c = probe_data[c*DATA_W +: DATA_W];
    end
  end

  // A pending forced capture wins; a periodic one is also held off in the
  // step cycle itself so a coincident terminal count yields a single tick.
  assign ref_term_c = (ref_cnt_q == REF_W'(REFRESH_DIV - 1));
  assign cap_c      = step_q || (ref_term_c && !freeze && !step_c);

  // Channel select, refresh counter, capture register and display
  always_ff @(posedge clk) begin
    if (rst) begin
      ch_sel      <= '0;
      step_q      <= 1'b0;
      ref_cnt_q   <= '0;
      cap_q       <= '0;
      sample_tick <= 1'b0;
      seg_out     <= seg_encode(DATA_W'(0));
    end else begin
      step_q      <= step_c;
      sample_tick <= cap_c;
      seg_out     <= seg_encode(cap_q);
      if (step_c) begin
        ch_sel <= (ch_sel == SEL_W'(NUM_CH - 1)) ? '0 : ch_sel + SEL_W'(1);
      end
      if (cap_c) cap_q <= slice_c;
      if (step_q || ref_term_c) ref_cnt_q <= '0;
      else                      ref_cnt_q <= ref_cnt_q + REF_W'(1);
    end
  end

endmodule

// File: tb/tb_seg7_probe_mux.sv
// Self-checking bench for seg7_probe_mux with randomized stimulus and a
// behavioural reference model (run-length debounce, modular refresh count).
module tb_seg7_probe_mux;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 16;
  localparam int REF    = 8;
  localparam int DEB    = 4;

  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] probe_data;
  logic        btn_next;
  logic        freeze;
  logic [1:0]  ch_sel;
  logic        sample_tick;
  logic [27:0] seg_out;

  int n_tests = 0;
  int n_fail  = 0;
  int tick_cnt = 0;

  // reference model state
  logic        m_sy1, m_sy2, m_held, m_pend, m_tick;
  int          m_hi, m_lo, m_ch, m_cnt;
  logic [15:0] m_cap;
  logic [27:0] m_seg;

  always #5 clk = ~clk;

  seg7_probe_mux #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .REFRESH_DIV(REF), .DEBOUNCE_CYC(DEB)
  ) dut (
    .clk(clk), .rst(rst), .probe_data(probe_data), .btn_next(btn_next),
    .freeze(freeze), .ch_sel(ch_sel), .sample_tick(sample_tick), .seg_out(seg_out)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [27:0] ref_seg(input logic [15:0] v);
    logic [27:0] r;
`ifdef SEG7_LZ_BLANK_EN
    int top;
    top = 0;
    for (int k = 0; k < 4; k++) if (v[k*4 +: 4] != 4'h0) top = k;
`endif
    r = '0;
    for (int k = 0; k < 4; k++) begin
      r[k*7 +: 7] = GLYPH[v[k*4 +: 4]];
`ifdef SEG7_LZ_BLANK_EN
      if (k > top) r[k*7 +: 7] = 7'h7F;
`endif
    end
    return r;
  endfunction

  function automatic logic [27:0] digits(input logic [6:0] d3, input logic [6:0] d2,
                                         input logic [6:0] d1, input logic [6:0] d0);
    return {d3, d2, d1, d0};
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge
  task automatic model_edge();
    logic        step, cap;
    logic [27:0] nseg;
    if (rst) begin
      m_sy1 = 0; m_sy2 = 0; m_held = 0; m_pend = 0; m_tick = 0;
      m_hi = 0; m_lo = 0; m_ch = 0; m_cnt = 0; m_cap = '0;
      m_seg = ref_seg(16'h0000);
      return;
    end
    nseg = ref_seg(m_cap);
    step = 1'b0;
    if (m_sy2) begin m_hi++; m_lo = 0; end
    else       begin m_lo++; m_hi = 0; end
    if (!m_held && m_hi == DEB) begin step = 1'b1; m_held = 1'b1; end
    if (m_held && m_lo == DEB) m_held = 1'b0;
    cap = m_pend || (m_cnt == REF - 1 && !freeze && !step);
    if (cap) m_cap = probe_data[m_ch*DATA_W +: DATA_W];
    m_tick = cap;
    m_cnt  = (m_pend || m_cnt == REF - 1) ? 0 : m_cnt + 1;
    m_pend = step;
    if (step) m_ch = (m_ch + 1) % NUM_CH;
    m_seg = nseg;
    m_sy2 = m_sy1;
    m_sy1 = btn_next;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    if (sample_tick) tick_cnt++;
    check("ch_sel", 64'(ch_sel), 64'(m_ch));
    check("sample_tick", 64'(sample_tick), 64'(m_tick));
    check("seg_out", 64'(seg_out), 64'(m_seg));
  endtask

  task automatic press(input int hi, input int lo);
    btn_next = 1'b1;
    repeat (hi) cyc();
    btn_next = 1'b0;
    repeat (lo) cyc();
  endtask

  initial begin
    int first, steps, prev, len, cycles;
    rst = 1'b1; btn_next = 1'b0; freeze = 1'b0;
    probe_data = {16'h0F0F, 16'hA5C3, 16'hBEEF, 16'h1234};
    repeat (3) cyc();
`ifdef SEG7_LZ_BLANK_EN
    check("rst_seg", 64'(seg_out), 64'(digits(7'h7F, 7'h7F, 7'h7F, 7'h40)));
`else
    check("rst_seg", 64'(seg_out), 64'(digits(7'h40, 7'h40, 7'h40, 7'h40)));
`endif
    check("rst_ch", 64'(ch_sel), 64'd0);
    check("rst_tick", 64'(sample_tick), 64'd0);

    // first periodic capture and its display
    rst = 1'b0;
    first = 0;
    for (int i = 1; i <= 12; i++) begin
      cyc();
      if (sample_tick && first == 0) first = i;
      if (i == 9) check("seg_1234", 64'(seg_out), 64'(digits(7'h79, 7'h24, 7'h30, 7'h19)));
    end
    check("first_tick_cycle", 64'(first), 64'd8);

    // glitch shorter than the debounce window
    press(2, 10);
    check("short_press_ch", 64'(ch_sel), 64'd0);

    // long hold gives exactly one step and a forced capture of ch1
    steps = 0; prev = int'(ch_sel);
    btn_next = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (i == 20) btn_next = 1'b0;
      cyc();
      if (int'(ch_sel) != prev) begin steps++; prev = int'(ch_sel); end
    end
    check("hold_steps", 64'(steps), 64'd1);
    check("hold_ch", 64'(ch_sel), 64'd1);
    check("seg_beef", 64'(seg_out), 64'(digits(7'h03, 7'h06, 7'h06, 7'h0E)));

    // walk to ch3, then wrap through 0,1,2,3
    press(8, 8);
    press(8, 8);
    check("ch_before_wrap", 64'(ch_sel), 64'd3);
    for (int p = 0; p < 4; p++) begin
      press(8, 8);
      check("wrap_seq", 64'(ch_sel), 64'(p));
    end

    // step landing on the refresh terminal count (capture edge, then step edge)
    for (int c0 = 1; c0 <= 2; c0++) begin
      for (int i = 0; i < 16; i++) begin
        if (m_cnt == c0) break;
        cyc();
      end
      tick_cnt = 0;
      btn_next = 1'b1;
      repeat (8) cyc();
      check("coincident_ticks", 64'(tick_cnt), 64'd1);
      btn_next = 1'b0;
      repeat (8) cyc();
    end

    // back to ch0, let it capture, then freeze
    press(8, 8); press(8, 8); press(8, 8);
    check("ch_before_freeze", 64'(ch_sel), 64'd0);
    repeat (10) cyc();
    freeze = 1'b1;
    probe_data[15:0] = 16'h5678;
    tick_cnt = 0;
    repeat (3 * REF) cyc();
    check("freeze_ticks", 64'(tick_cnt), 64'd0);
    check("freeze_seg", 64'(seg_out), 64'(digits(7'h79, 7'h24, 7'h30, 7'h19)));
    tick_cnt = 0;
    press(8, 8);
    check("freeze_step_ticks", 64'(tick_cnt), 64'd1);
    check("freeze_step_ch", 64'(ch_sel), 64'd1);
    check("freeze_step_seg", 64'(seg_out), 64'(digits(7'h03, 7'h06, 7'h06, 7'h0E)));
    freeze = 1'b0;

    // reset in the middle of a debounce abandons the step
    btn_next = 1'b1;
    repeat (4) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0; btn_next = 1'b0;
    repeat (10) cyc();
    check("rst_mid_debounce_ch", 64'(ch_sel), 64'd0);

    // randomized run
    cycles = 0;
    while (cycles < 1500) begin
      btn_next = 1'($urandom_range(0, 1));
      len      = int'($urandom_range(1, 9));
      freeze   = ($urandom_range(0, 3) == 0);
      repeat (len) begin
        if ($urandom_range(0, 3) == 0) probe_data = {$urandom, $urandom};
        rst = ($urandom_range(0, 199) == 0);
        cyc();
        cycles++;
      end
    end
    rst = 1'b0; btn_next = 1'b0; freeze = 1'b0;
    repeat (10) cyc();

`ifdef SEG7_LZ_BLANK_EN
    rst = 1'b1; cyc(); rst = 1'b0;
    probe_data[15:0] = 16'h0042;
    repeat (10) cyc();
    check("blank_0042", 64'(seg_out), 64'(digits(7'h7F, 7'h7F, 7'h19, 7'h24)));
    probe_data[15:0] = 16'h0000;
    repeat (10) cyc();
    check("blank_0000", 64'(seg_out), 64'(digits(7'h7F, 7'h7F, 7'h7F, 7'h40)));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
